// File: rtl/down_counter_pkg.sv
// Shared encodings and default sizing for the loadable down counter.
package down_counter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DOWN_COUNTER_WIDTH = 4;

endpackage

// File: rtl/down_counter_if.sv
// Load/control/status bundle for down_counter; master drives loads, slave is the counter.
interface down_counter_if
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DOWN_COUNTER_WIDTH
);

  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             enable;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load_valid,
    output load_value,
    output enable,
    output stop,
    input  load_ready,
    input  count,
    input  busy,
    input  done
  );

  modport slave (
    input  load_valid,
    input  load_value,
    input  enable,
    input  stop,
    output load_ready,
    output count,
    output busy,
    output done
  );

endinterface

// File: rtl/down_counter_dec.sv
// Combinational borrow-chain decrementer with is_one / is_zero detect.
module down_counter_dec
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DOWN_COUNTER_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] dec,
  output logic             is_one,
  output logic             is_zero
);

  logic [WIDTH:0] borrow;
  logic           zero_hi;

  // Ripple borrow: a bit flips while every lower bit is still zero.
  always_comb begin
    borrow    = '0;
    dec       = '0;
    borrow[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      dec[i]      = a[i] ^ borrow[i];
      borrow[i+1] = borrow[i] & ~a[i];
    end
  end

  always_comb begin
    zero_hi = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      zero_hi = zero_hi & ~a[i];
    end
  end

  // Borrow escaping the top bit means every input bit was zero.
  assign is_zero = borrow[WIDTH];
  assign is_one  = a[0] & zero_hi;

endmodule

// File: rtl/down_counter.sv
// Loadable down counter with valid/ready load, enable, stop and registered done pulse.
// Optional periodic mode: define DOWN_COUNTER_AUTORELOAD_EN.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DOWN_COUNTER_WIDTH
) (
  input logic               clk,
  input logic               reset,
  down_counter_if.slave     bus
);

  state_t           state_p0;
  logic [WIDTH-1:0] count_p0;
  logic             done_p0;
  logic [WIDTH-1:0] count_dec;
  logic             count_is_one;
  logic             count_is_zero;
  logic             load_is_zero;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_p0;
`endif

  down_counter_dec #(
    .WIDTH (WIDTH)
  ) u_dec (
    .a       (count_p0),
    .dec     (count_dec),
    .is_one  (count_is_one),
    .is_zero (count_is_zero)
  );

  assign load_is_zero = (bus.load_value == '0);

  // ---- state / count / done register stage ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_p0  <= ST_IDLE;
      count_p0  <= '0;
      done_p0   <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload_p0 <= '0;
`endif
    end else begin
      done_p0 <= 1'b0;
      case (state_p0)
        ST_IDLE: begin
          if (bus.load_valid) begin
            count_p0  <= bus.load_value;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload_p0 <= bus.load_value;
`endif
            // A zero load is already terminal: pulse done without entering RUN.
            if (load_is_zero) begin
              done_p0 <= 1'b1;
            end else begin
              state_p0 <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_p0 <= ST_IDLE;
          end else if (bus.enable) begin
            if (count_is_one) begin
              done_p0 <= 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
              count_p0 <= reload_p0;
`else
              count_p0 <= '0;
              state_p0 <= ST_IDLE;
`endif
            end else if (!count_is_zero) begin
              count_p0 <= count_dec;
            end
          end
        end
        default: state_p0 <= ST_IDLE;
      endcase
    end
  end

  assign bus.count      = count_p0;
  assign bus.done       = done_p0;
  assign bus.busy       = (state_p0 == ST_RUN);
  assign bus.load_ready = (state_p0 == ST_IDLE);

  // RUN is only entered with a nonzero count and leaves before reaching zero.
  a_run_nonzero: assert property (@(posedge clk) disable iff (!reset)
    (state_p0 == ST_RUN) |-> (count_p0 != '0));

endmodule

// File: tb/tb_down_counter.sv
// Testbench for down_counter; autoreload scenarios run when DOWN_COUNTER_AUTORELOAD_EN is defined.
module tb_down_counter;
  import down_counter_pkg::*;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  down_counter_if #(.WIDTH(W)) bus ();

  down_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.load_valid = 1'b0;
    bus.load_value = '0;
    bus.enable     = 1'b0;
    bus.stop       = 1'b0;
  endtask

  task automatic test_reset;
    reset          = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd5;
    bus.enable     = 1'b1;
    bus.stop       = 1'b0;
    repeat (3) tick();
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_tests++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.load_ready); end
    idle_inputs();
    reset = 1'b1;
    tick();
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_release_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_zero_load;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd0;
    tick();
    bus.load_valid = 1'b0;
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero_load_done got=%b exp=1", bus.done); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_load_busy got=%b exp=0", bus.busy); end
    n_tests++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL zero_load_ready got=%b exp=1", bus.load_ready); end
    tick();
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_load_done_fall got=%b exp=0", bus.done); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_load_busy2 got=%b exp=0", bus.busy); end
  endtask

  task automatic test_ignored_load;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd6;
    tick();
    n_tests++; if (bus.count !== 4'd6) begin n_fail++; $display("FAIL ign_load_count got=%0d exp=6", bus.count); end
    bus.load_value = 4'd9;
    bus.enable     = 1'b1;
    tick();
    n_tests++; if (bus.count !== 4'd5) begin n_fail++; $display("FAIL ign_load_ignored got=%0d exp=5", bus.count); end
    n_tests++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL ign_load_ready got=%b exp=0", bus.load_ready); end
    bus.load_valid = 1'b0;
    bus.stop       = 1'b1;
    tick();
    idle_inputs();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ign_load_stop_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_abort;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd2;
    bus.enable     = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    tick();
    n_tests++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL abort_pre_count got=%0d exp=1", bus.count); end
    bus.stop = 1'b1;
    tick();
    n_tests++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL abort_count got=%0d exp=1", bus.count); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", bus.done); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    n_tests++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got=%b exp=1", bus.load_ready); end
    idle_inputs();
    tick();
    n_tests++; if (bus.done !== 1'b0 || bus.count !== 4'd1) begin
      n_fail++; $display("FAIL abort_after got done=%b count=%0d exp done=0 count=1", bus.done, bus.count);
    end
  endtask

  task automatic test_reset_mid_run;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd3;
    bus.enable     = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    tick();
    n_tests++; if (bus.count !== 4'd2) begin n_fail++; $display("FAIL midrst_pre_count got=%0d exp=2", bus.count); end
    reset = 1'b0;
    tick();
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", bus.count); end
    n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state got busy=%b done=%b exp busy=0 done=0", bus.busy, bus.done);
    end
    reset = 1'b1;
    idle_inputs();
    tick();
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done got=%b exp=0", bus.done); end
  endtask

`ifndef DOWN_COUNTER_AUTORELOAD_EN
  task automatic test_one_shot;
    logic [W-1:0] exp_c;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd3;
    bus.enable     = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    n_tests++; if (bus.count !== 4'd3 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_load got count=%0d busy=%b exp count=3 busy=1", bus.count, bus.busy);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp_c = W'(3 - k);
      n_tests++; if (bus.count !== exp_c) begin n_fail++; $display("FAIL oneshot_count k=%0d got=%0d exp=%0d", k, bus.count, exp_c); end
      n_tests++; if (bus.done !== (k == 3)) begin n_fail++; $display("FAIL oneshot_done k=%0d got=%b exp=%b", k, bus.done, (k == 3)); end
      n_tests++; if (bus.busy !== (k < 3)) begin n_fail++; $display("FAIL oneshot_busy k=%0d got=%b exp=%b", k, bus.busy, (k < 3)); end
    end
    n_tests++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL oneshot_ready_at_done got=%b exp=1", bus.load_ready); end
    // back-to-back load on the edge right after done
    bus.load_valid = 1'b1;
    bus.load_value = 4'd2;
    tick();
    bus.load_valid = 1'b0;
    n_tests++; if (bus.count !== 4'd2 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_load got count=%0d busy=%b done=%b exp 2/1/0", bus.count, bus.busy, bus.done);
    end
    bus.stop = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_gated_enable;
    int n;
    int cyc;
    bit en;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd4;
    tick();
    bus.load_valid = 1'b0;
    n   = 0;
    cyc = 0;
    while (n < 4 && cyc < 20) begin
      en = (cyc % 2 == 0);
      bus.enable = en;
      tick();
      cyc++;
      if (en) n++;
      n_tests++; if (bus.count !== W'(4 - n)) begin n_fail++; $display("FAIL gated_count cyc=%0d got=%0d exp=%0d", cyc, bus.count, 4 - n); end
      n_tests++; if (bus.done !== (en && n == 4)) begin n_fail++; $display("FAIL gated_done cyc=%0d got=%b exp=%b", cyc, bus.done, (en && n == 4)); end
    end
    n_tests++; if (cyc !== 7) begin n_fail++; $display("FAIL gated_latency got=%0d exp=7", cyc); end
    idle_inputs();
    tick();
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL gated_done_fall got=%b exp=0", bus.done); end
  endtask

  task automatic test_random;
    int v;
    int n;
    int cyc;
    bit en;
    for (int trial = 0; trial < 10; trial++) begin
      v = $urandom_range(1, MAXV);
      bus.load_valid = 1'b1;
      bus.load_value = W'(v);
      bus.enable     = 1'b0;
      tick();
      n_tests++; if (bus.count !== W'(v) || bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL rand_load t=%0d got count=%0d busy=%b exp count=%0d busy=1", trial, bus.count, bus.busy, v);
      end
      n   = 0;
      cyc = 0;
      while (n < v) begin
        en = (cyc >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.enable     = en;
        bus.load_valid = 1'($urandom_range(0, 1));
        bus.load_value = W'($urandom_range(0, MAXV));
        tick();
        cyc++;
        if (en) n++;
        n_tests++; if (bus.count !== W'(v - n)) begin n_fail++; $display("FAIL rand_count t=%0d cyc=%0d got=%0d exp=%0d", trial, cyc, bus.count, v - n); end
        n_tests++; if (bus.done !== (en && n == v)) begin n_fail++; $display("FAIL rand_done t=%0d cyc=%0d got=%b exp=%b", trial, cyc, bus.done, (en && n == v)); end
        n_tests++; if (bus.busy !== (n < v)) begin n_fail++; $display("FAIL rand_busy t=%0d cyc=%0d got=%b exp=%b", trial, cyc, bus.busy, (n < v)); end
      end
      idle_inputs();
      tick();
      n_tests++; if (bus.done !== 1'b0 || bus.count !== 4'd0) begin
        n_fail++; $display("FAIL rand_end t=%0d got done=%b count=%0d exp done=0 count=0", trial, bus.done, bus.count);
      end
    end
  endtask
`else
  task automatic test_autoreload;
    int pulses;
    logic [W-1:0] exp_c;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd2;
    bus.enable     = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_c = (k % 2 == 1) ? 4'd1 : 4'd2;
      if (bus.done === 1'b1) pulses++;
      n_tests++; if (bus.count !== exp_c) begin n_fail++; $display("FAIL auto_count k=%0d got=%0d exp=%0d", k, bus.count, exp_c); end
      n_tests++; if (bus.done !== (k % 2 == 0)) begin n_fail++; $display("FAIL auto_done k=%0d got=%b exp=%b", k, bus.done, (k % 2 == 0)); end
      n_tests++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL auto_ready k=%0d got=%b exp=0", k, bus.load_ready); end
    end
    n_tests++; if (pulses !== 5) begin n_fail++; $display("FAIL auto_pulses got=%0d exp=5", pulses); end
    bus.stop = 1'b1;
    tick();
    idle_inputs();
    n_tests++; if (bus.busy !== 1'b0 || bus.load_ready !== 1'b1) begin
      n_fail++; $display("FAIL auto_stop got busy=%b ready=%b exp busy=0 ready=1", bus.busy, bus.load_ready);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    idle_inputs();
    test_reset();
    test_zero_load();
    test_ignored_load();
    test_abort();
    test_reset_mid_run();
`ifndef DOWN_COUNTER_AUTORELOAD_EN
    test_one_shot();
    test_gated_enable();
    test_random();
`else
    test_autoreload();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
